// File: rtl/serial_frame_rx.sv
// Strobe-framed serial receiver: start bit, MSB-first data, stop bit,
// one-entry holding register with valid/ready handshake and dsr flow control.
module serial_frame_rx #(
    parameter int BIT_PERIOD = 106,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ser_in,
    output logic                 dsr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    // Timer holds 1..BIT_PERIOD, so it needs room for BIT_PERIOD itself
    localparam int TW = $clog2(BIT_PERIOD + 1);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(BIT_PERIOD);
    localparam logic [TW-1:0] TONE  = TW'(1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BONE  = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TW-1:0]         r_timer;
    logic [BW-1:0]         r_bidx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_ferr;
    logic                  r_ovr;

    logic                  w_strobe;
    logic                  w_bit;
    logic                  w_stop;
    logic                  w_full;
    logic                  w_load;
    logic                  w_ovr;
    logic                  w_ferr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!ser_in) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit && (r_bidx == BLAST)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_strobe) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_strobe = 1'b0;
        w_bit    = 1'b0;
        w_stop   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_strobe = 1'b0;
            end
            S_DATA: begin
                w_strobe = (r_timer == TMAX);
                w_bit    = w_strobe;
            end
            S_STOP: begin
                w_strobe = (r_timer == TMAX);
                w_stop   = w_strobe;
            end
            default: begin
                w_strobe = 1'b0;
            end
        endcase
    end

    // A consumer accepting in the stop cycle frees the slot for the new byte
    assign w_full = r_valid && !rx_ready;
    assign w_load = w_stop && ser_in && !w_full;
    assign w_ovr  = w_stop && ser_in && w_full;
    assign w_ferr = w_stop && !ser_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= TONE;
            r_bidx  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_ferr <= w_ferr;
            r_ovr  <= w_ovr;

            if ((r_state == S_IDLE) || w_strobe) begin
                r_timer <= TONE;
            end else begin
                r_timer <= r_timer + TONE;
            end

            if (r_state == S_IDLE) begin
                r_bidx <= '0;
            end else if (w_bit && (r_bidx != BLAST)) begin
                r_bidx <= r_bidx + BONE;
            end

            if (w_bit) begin
                r_shift[BLAST - r_bidx] <= ser_in;
            end

            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign dsr       = ~r_valid;
    assign busy      = r_busy;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule
